seq_bus_datapath: RTL and testbench
===================================

Name: seq_bus_datapath

Overview:
- Parametrised single-bus datapath: register file, Y, Z (double-width), HI/LO and bus mux, plus an internal micro-step sequencer.
- Runs one three-register ALU instruction per start handshake by stepping the bus transfers itself.
- Lets the processor core and the bench issue whole operations rather than hand-driving per-register in/out strobes.

Parameters:
- WIDTH, 32, data/bus width in bits (power of two, >=8).
- NUM_REGS, 16, general-purpose register count (power of two, 2..32).
- ZERO_R0, 1, when 1 R0 reads as 0 and writes to R0 are discarded.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 NEG, 7 NOT, 8 MUL (unsigned); others illegal.
- ra  in  log2(NUM_REGS)  destination register.
- rb  in  log2(NUM_REGS)  source A.
- rc  in  log2(NUM_REGS)  source B / shift amount; ignored for NEG and NOT.
- ld_en  in  1  external register load, honoured only in IDLE.
- ld_sel  in  log2(NUM_REGS)  load target.
- ld_data  in  WIDTH  load value.
- rd_sel  in  log2(NUM_REGS)  observation select.
- rd_data  out  WIDTH  combinational read of R[rd_sel], honouring ZERO_R0.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- bus_out  out  WIDTH  current bus value; 0 when no source is driving.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse, valid the cycle the result is written.
- err  out  1  one-cycle pulse on an illegal op.

Behaviour:
- Reset (Clear high, asynchronous): all registers, Y, Z, HI, LO cleared to 0; FSM to IDLE; busy, done, err driven 0. Clear mid-operation aborts the operation and produces no write and no done.
- Bus is a one-hot-source mux; exactly one source drives per micro-step, otherwise 0.
- FSM states and transitions:
  - IDLE: if start, latch op/ra/rb/rc and go to T1. start has priority over ld_en in the same cycle; the load is dropped.
  - T1: R[rb] on bus, Y loaded. If op is illegal, pulse err and return to IDLE with no writes.
  - T2: R[rc] on bus (0 for NEG/NOT); ALU computes from Y and bus; Z (2*WIDTH) loaded.
  - T3: Z_lo on bus. Non-MUL ops: R[ra] loaded, done=1, go to IDLE. MUL: LO loaded, go to T4.
  - T4 (MUL only): Z_hi on bus, HI loaded, done=1, go to IDLE.
- Latency: start at edge N yields done high in cycle N+3 (N+4 for MUL). The next start is accepted in the cycle after done.
- start while busy: ignored, not queued. ld_en while busy: ignored.
- ld_en in IDLE: R[ld_sel] <= ld_data at the next edge.
- Arithmetic:
  - ADD, SUB and NEG wrap modulo 2^WIDTH; Z_hi = 0.
  - SHL/SHR: amount is the full R[rc] value; amount >= WIDTH gives 0.
  - MUL: full 2*WIDTH unsigned product, combinational in T2.
- ZERO_R0=1:
  - R0 as a source reads 0.
  - ra=0 completes normally with done pulsed, but R0 stays 0.
  - ld_sel=0 is dropped.
- ra equal to rb or rc is legal; sources are captured in T1/T2 before the T3 write.
- HI/LO change only on MUL. R[ra] is unchanged by MUL.

Test Plan:
- Reset: load R1=5 and R2=7, assert Clear mid-ADD at T2 -> all reads 0, busy=0, no done pulse, FSM accepts a new start next cycle.
- ADD timing: R1=0xFFFFFFFF, R2=2, start op=0 ra=3 rb=1 rc=2 -> done exactly 3 cycles later, R3=0x00000001, busy high for T1..T3.
- MUL: R4=0x80000000, R5=4, op=8 -> LO=0x00000000, HI=0x00000002, done at 4 cycles, R[ra] unchanged.
- Shift boundaries: R6=0x0000F00F; SHL by R7=4 -> 0x000F00F0; SHR by R7=32 -> 0; SHR by R7=1 -> 0x00007807.
- R0 and aliasing: op=0 ra=0 rb=1 rc=1 -> done pulses, R0 reads 0; op=1 ra=1 rb=1 rc=2 with R1=10, R2=3 -> R1=7.
- Protocol: start during busy ignored (exactly one done); ld_en during busy ignored; op=0xF -> err pulse in T1, no register change, IDLE next cycle.

Source files
------------

// File: rtl/seq_bus_datapath_if.sv
// Operation request, register load/observe and status bundle for seq_bus_datapath.
interface seq_bus_datapath_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16
);
  localparam int RW = $clog2(NUM_REGS);

  logic             start;
  logic [3:0]       op;
  logic [RW-1:0]    ra;
  logic [RW-1:0]    rb;
  logic [RW-1:0]    rc;
  logic             ld_en;
  logic [RW-1:0]    ld_sel;
  logic [WIDTH-1:0] ld_data;
  logic [RW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] bus_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
    input  rd_data, hi_out, lo_out, bus_out, busy, done, err
  );

  modport slave (
    input  start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
    output rd_data, hi_out, lo_out, bus_out, busy, done, err
  );
endinterface

// File: rtl/seq_bus_datapath.sv
// Single-bus datapath (regfile, Y, double-width Z, HI/LO) with a built-in
// micro-step sequencer running one three-register ALU op per start.
module seq_bus_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seq_bus_datapath_if.slave sb
);
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // One-hot bus source positions
  localparam int SRC_RB  = 0;
  localparam int SRC_RC  = 1;
  localparam int SRC_ZLO = 2;
  localparam int SRC_ZHI = 3;

  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_e;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [RW-1:0] rc;
  } req_t;

  state_e                         state, state_nx;
  req_t                           req;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]               y_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]             z_q, alu_z;
  logic [WIDTH-1:0]               bus, rb_val, rc_val;
  logic [3:0]                     bus_src;
  logic                           y_ld, z_ld, r_wr, lo_ld, hi_ld;
  logic                           done_c, err_c;
  logic                           op_legal, op_mul, op_unary, ld_accept;

  function automatic logic [WIDTH-1:0] rf_rd(
    input logic [NUM_REGS-1:0][WIDTH-1:0] rf,
    input logic [RW-1:0]                  sel
  );
    if (ZERO_R0 && sel == '0) return '0;
    return rf[sel];
  endfunction

  function automatic logic writable(input logic [RW-1:0] sel);
    return !(ZERO_R0 && sel == '0);
  endfunction

  assign op_legal  = (req.op <= OP_MUL);
  assign op_mul    = (req.op == OP_MUL);
  assign op_unary  = (req.op == OP_NEG) || (req.op == OP_NOT);
  // start wins over a same-cycle load
  assign ld_accept = (state == S_IDLE) && !sb.start && sb.ld_en;

  assign rb_val = rf_rd(regs, req.rb);
  assign rc_val = rf_rd(regs, req.rc);

  assign bus = ({WIDTH{bus_src[SRC_RB]}}  & rb_val)
             | ({WIDTH{bus_src[SRC_RC]}}  & rc_val)
             | ({WIDTH{bus_src[SRC_ZLO]}} & z_q[WIDTH-1:0])
             | ({WIDTH{bus_src[SRC_ZHI]}} & z_q[2*WIDTH-1:WIDTH]);

  // ALU: A operand from Y, B operand from the bus during T2
  always_comb begin
    alu_z = '0;
    case (req.op)
      OP_ADD: alu_z[WIDTH-1:0] = y_q + bus;
      OP_SUB: alu_z[WIDTH-1:0] = y_q - bus;
      OP_AND: alu_z[WIDTH-1:0] = y_q & bus;
      OP_OR:  alu_z[WIDTH-1:0] = y_q | bus;
      OP_SHL: alu_z[WIDTH-1:0] = (bus >= SH_LIM) ? '0 : (y_q << bus);
      OP_SHR: alu_z[WIDTH-1:0] = (bus >= SH_LIM) ? '0 : (y_q >> bus);
      OP_NEG: alu_z[WIDTH-1:0] = '0 - y_q;
      OP_NOT: alu_z[WIDTH-1:0] = ~y_q;
      OP_MUL: alu_z = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus};
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus_src  = '0;
    y_ld     = 1'b0;
    z_ld     = 1'b0;
    r_wr     = 1'b0;
    lo_ld    = 1'b0;
    hi_ld    = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (state)
      S_IDLE: if (sb.start) state_nx = S_T1;
      S_T1: begin
        bus_src[SRC_RB] = 1'b1;
        if (!op_legal) begin
          err_c    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          y_ld     = 1'b1;
          state_nx = S_T2;
        end
      end
      S_T2: begin
        bus_src[SRC_RC] = !op_unary;
        z_ld            = 1'b1;
        state_nx        = S_T3;
      end
      S_T3: begin
        bus_src[SRC_ZLO] = 1'b1;
        if (op_mul) begin
          lo_ld    = 1'b1;
          state_nx = S_T4;
        end else begin
          r_wr     = 1'b1;
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_T4: begin
        bus_src[SRC_ZHI] = 1'b1;
        hi_ld            = 1'b1;
        done_c           = 1'b1;
        state_nx         = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      req  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (state == S_IDLE && sb.start)
        req <= '{op: sb.op, ra: sb.ra, rb: sb.rb, rc: sb.rc};
      if (y_ld)  y_q  <= bus;
      if (z_ld)  z_q  <= alu_z;
      if (lo_ld) lo_q <= bus;
      if (hi_ld) hi_q <= bus;
      // r_wr only in T3, ld_accept only in IDLE: never both
      if (r_wr && writable(req.ra))
        regs[req.ra] <= bus;
      else if (ld_accept && writable(sb.ld_sel))
        regs[sb.ld_sel] <= sb.ld_data;
    end
  end

  assign sb.rd_data = rf_rd(regs, sb.rd_sel);
  assign sb.hi_out  = hi_q;
  assign sb.lo_out  = lo_q;
  assign sb.bus_out = bus;
  assign sb.busy    = (state != S_IDLE);
  assign sb.done    = done_c;
  assign sb.err     = err_c;
endmodule

// File: tb/tb_seq_bus_datapath.sv
// Randomized + directed bench for seq_bus_datapath against an op-level model.
module tb_seq_bus_datapath;
  localparam int W  = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_bus_datapath_if #(.WIDTH(W), .NUM_REGS(NR)) sb();

  seq_bus_datapath #(.WIDTH(W), .NUM_REGS(NR), .ZERO_R0(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscmp  = 0;

  logic [W-1:0] m_r [NR];
  logic [W-1:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_r[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Op semantics as plain arithmetic; returns {hi, lo}
  function automatic logic [63:0] ref_z(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return {32'h0, a + b};
      1: return {32'h0, a - b};
      2: return {32'h0, a & b};
      3: return {32'h0, a | b};
      4: return (b >= 32) ? 64'h0 : {32'h0, a << b};
      5: return (b >= 32) ? 64'h0 : {32'h0, a >> b};
      6: return {32'h0, -a};
      7: return {32'h0, ~a};
      8: return 64'(a) * 64'(b);
      default: return 64'h0;
    endcase
  endfunction

  task automatic ld(input int sel, input logic [W-1:0] d);
    sb.ld_en   = 1'b1;
    sb.ld_sel  = 4'(sel);
    sb.ld_data = d;
    step();
    sb.ld_en = 1'b0;
    if (sel != 0) m_r[sel] = d;
  endtask

  task automatic chk_state(input string tag);
    for (int r = 0; r < NR; r++) begin
      sb.rd_sel = 4'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), sb.rd_data, m_r[r]);
    end
    chk({tag, "_hi"}, sb.hi_out, m_hi);
    chk({tag, "_lo"}, sb.lo_out, m_lo);
    step();
  endtask

  task automatic run_op(input string tag, input int op, input int ra, input int rb,
                        input int rc, input bit noise, input bit with_ld);
    int lat, dcyc, dcnt, ecnt, bcnt;
    logic [31:0] a, b;
    logic [63:0] z;
    bit legal;
    legal = (op <= 8);
    lat   = !legal ? 1 : (op == 8) ? 4 : 3;
    a     = (rb == 0) ? 32'h0 : m_r[rb];
    b     = (op == 6 || op == 7 || rc == 0) ? 32'h0 : m_r[rc];
    dcyc = 0; dcnt = 0; ecnt = 0; bcnt = 0;

    sb.op    = 4'(op);
    sb.ra    = 4'(ra);
    sb.rb    = 4'(rb);
    sb.rc    = 4'(rc);
    sb.start = 1'b1;
    if (with_ld) begin
      sb.ld_en   = 1'b1;
      sb.ld_sel  = 4'(rb | 1);
      sb.ld_data = $urandom;
    end
    step();
    sb.start = 1'b0;
    sb.ld_en = 1'b0;

    for (int i = 1; i <= 6; i++) begin
      if (sb.done) begin
        dcnt++;
        if (dcyc == 0) dcyc = i;
      end
      if (sb.err)  ecnt++;
      if (sb.busy) bcnt++;
      if (noise && i == 1) begin
        sb.start   = 1'b1;
        sb.op      = 4'd0;
        sb.ld_en   = 1'b1;
        sb.ld_sel  = 4'(rb | 1);
        sb.ld_data = $urandom;
      end else begin
        sb.start = 1'b0;
        sb.ld_en = 1'b0;
      end
      step();
    end
    chk({tag, "_done_cyc"}, 64'(dcyc), legal ? 64'(lat) : 64'd0);
    chk({tag, "_done_cnt"}, 64'(dcnt), legal ? 64'd1 : 64'd0);
    chk({tag, "_err_cnt"},  64'(ecnt), legal ? 64'd0 : 64'd1);
    chk({tag, "_busy_cyc"}, 64'(bcnt), 64'(lat));
    chk({tag, "_bus_idle"}, sb.bus_out, 64'd0);

    if (legal) begin
      z = ref_z(op, a, b);
      if (op == 8) begin
        m_hi = z[63:32];
        m_lo = z[31:0];
      end else if (ra != 0) begin
        m_r[ra] = z[31:0];
      end
    end
    chk_state(tag);
  endtask

  initial begin
    int dcnt;
    sb.start = 0; sb.op = 0; sb.ra = 0; sb.rb = 0; sb.rc = 0;
    sb.ld_en = 0; sb.ld_sel = 0; sb.ld_data = 0; sb.rd_sel = 0;
    model_clear();

    #3;
    chk("rst_busy", sb.busy, 0);
    chk("rst_done", sb.done, 0);
    chk("rst_err",  sb.err, 0);
    chk("rst_bus",  sb.bus_out, 0);
    #10 rst = 1'b0;
    step();
    chk_state("rst");

    // Clear mid-ADD at T2
    ld(1, 32'd5);
    ld(2, 32'd7);
    sb.op = 4'd0; sb.ra = 4'd3; sb.rb = 4'd1; sb.rc = 4'd2; sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("clr_busy", sb.busy, 0);
    chk("clr_done", sb.done, 0);
    #1 rst = 1'b0;
    model_clear();
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (sb.done) dcnt++;
    end
    chk("clr_no_done", 64'(dcnt), 0);
    chk_state("clr");
    run_op("post_clr", 0, 3, 1, 2, 0, 0);

    ld(1, 32'hFFFF_FFFF);
    ld(2, 32'd2);
    run_op("add_wrap", 0, 3, 1, 2, 0, 0);

    ld(4, 32'h8000_0000);
    ld(5, 32'd4);
    ld(6, 32'h1234_5678);
    run_op("mul", 8, 6, 4, 5, 0, 0);

    ld(6, 32'h0000_F00F);
    ld(7, 32'd4);
    run_op("shl4", 4, 8, 6, 7, 0, 0);
    ld(7, 32'd32);
    run_op("shr32", 5, 8, 6, 7, 0, 0);
    ld(7, 32'd1);
    run_op("shr1", 5, 8, 6, 7, 0, 0);

    run_op("r0_dst", 0, 0, 1, 1, 0, 0);
    ld(1, 32'd10);
    ld(2, 32'd3);
    run_op("alias_sub", 1, 1, 1, 2, 0, 0);

    ld(0, 32'hDEAD_BEEF);
    chk_state("ld_r0");

    run_op("busy_noise", 0, 9, 1, 2, 1, 0);
    run_op("illegal", 15, 9, 1, 2, 1, 0);
    run_op("start_ld", 3, 10, 1, 2, 0, 1);
    run_op("neg", 6, 11, 2, 0, 0, 0);
    run_op("not", 7, 12, 2, 5, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int nl, op;
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++)
        ld($urandom_range(0, NR - 1),
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom));
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      run_op($sformatf("rnd%0d", n), op, $urandom_range(0, NR - 1),
             $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
